// File: rtl/cp0_regs_pkg.sv
// cp0_regs_pkg: shared CP0 definitions.
//   - CP0 register numbers (MFC0/MTC0 rd field)
//   - ExcCode values of the exceptions this core commits
//   - Status/Cause bit positions and the Status write mask
//   - is_addr_exc(): true for exceptions that latch BadVAddr
package cp0_regs_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

  localparam int unsigned STATUS_BEV   = 22;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IE    = 0;

  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_TI     = 30;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_EXC_LO = 2;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_we_count       : load Count from i_wdata
//   i_we_compare     : load Compare from i_wdata, clears TI
//   i_wdata          : MTC0 write data
//   o_count          : current Count
//   o_compare        : current Compare
//   o_ti             : timer interrupt flag (Cause.TI)
// Count advances once every two clocks via a free-running toggle; a
// Count load does not disturb the toggle phase.
module cp0_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick    <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;

      if (i_we_count)
        r_count <= i_wdata;
      else if (r_tick)
        r_count <= r_count + 32'd1;

      // A Compare write wins over a match seen on the same edge.
      if (i_we_compare) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS CP0 register file (BadVAddr, Count, Compare, Status,
// Cause, EPC) with exception/ERET commit and interrupt request.
//   clk, rst        : clock, synchronous active-high reset
//   we/waddr/wdata  : MTC0 write port
//   raddr/rdata     : MFC0 read port (combinational, no write bypass)
//   exc_*           : exception commit (code, pc, delay slot, bad address)
//   eret            : ERET commit
//   hw_int          : level-sensitive hardware interrupt lines
//   epc_out/status_out/cause_out : current register images
//   int_pending     : unmasked interrupt request
// Same-cycle priority is exception > ERET > MTC0; losers are dropped.
module cp0_regs
  import cp0_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic        int_pending
);

  logic        w_eret_take;
  logic        w_wr;
  logic        w_we_count;
  logic        w_we_compare;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  assign w_eret_take  = eret & ~exc_valid;
  assign w_wr         = we & ~exc_valid & ~eret;
  assign w_we_count   = w_wr && (waddr == CP0_COUNT);
  assign w_we_compare = w_wr && (waddr == CP0_COMPARE);

  cp0_timer u_timer (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_we_count   (w_we_count),
    .i_we_compare (w_we_compare),
    .i_wdata      (wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      // IP7 carries the timer interrupt alongside hw_int[5].
      r_ip_hw <= {hw_int[5] | w_ti, hw_int[4:0]};

      if (exc_valid) begin
        if (!r_exl) begin
          r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          r_bd  <= exc_bd;
        end
        r_exl     <= 1'b1;
        r_exccode <= exc_code;
        if (is_addr_exc(exc_code))
          r_badvaddr <= exc_badvaddr;
      end else if (w_eret_take) begin
        r_exl <= 1'b0;
      end else if (w_wr) begin
        case (waddr)
          CP0_STATUS: begin
            r_im  <= wdata[15:8];
            r_exl <= wdata[1];
            r_ie  <= wdata[0];
          end
          CP0_CAUSE: r_ip_sw <= wdata[9:8];
          CP0_EPC:   r_epc   <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_status                         = '0;
    w_status[STATUS_BEV]             = 1'b1;
    w_status[STATUS_IM_LO +: 8]      = r_im;
    w_status[STATUS_EXL]             = r_exl;
    w_status[STATUS_IE]              = r_ie;
  end

  always_comb begin
    w_cause                          = '0;
    w_cause[CAUSE_BD]                = r_bd;
    w_cause[CAUSE_TI]                = w_ti;
    w_cause[CAUSE_IP_LO +: 8]        = {r_ip_hw, r_ip_sw};
    w_cause[CAUSE_EXC_LO +: 5]       = r_exccode;
  end

  always_comb begin
    case (raddr)
      CP0_BADVADDR: rdata = r_badvaddr;
      CP0_COUNT:    rdata = w_count;
      CP0_COMPARE:  rdata = w_compare;
      CP0_STATUS:   rdata = w_status;
      CP0_CAUSE:    rdata = w_cause;
      CP0_EPC:      rdata = r_epc;
      default:      rdata = '0;
    endcase
  end

  assign epc_out     = r_epc;
  assign status_out  = w_status;
  assign cause_out   = w_cause;
  assign int_pending = r_ie & ~r_exl & (|(r_im & {r_ip_hw, r_ip_sw}));

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed and randomized checks of cp0_regs against a
// register-image reference model.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic        int_pending;

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .hw_int       (hw_int),
    .epc_out      (epc_out),
    .status_out   (status_out),
    .cause_out    (cause_out),
    .int_pending  (int_pending)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: whole-register images. m_cause excludes TI (bit 30).
  logic [31:0] m_status, m_cause, m_epc, m_bva, m_count, m_compare;
  logic        m_ti;
  int unsigned m_edges;

  function automatic logic [31:0] exp_cause();
    return m_cause | ({31'd0, m_ti} << 30);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return exp_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_int();
    logic [31:0] c;
    c = exp_cause();
    return m_status[0] & ~m_status[1] & (|(m_status[15:8] & c[15:8]));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("status", status_out, m_status);
    check("cause", cause_out, exp_cause());
    check("epc", epc_out, m_epc);
    check("int_pending", {31'd0, int_pending}, {31'd0, exp_int()});
    check("rdata", rdata, exp_rdata(raddr));
  endtask

  // Advance one clock: compute the model's next state from current inputs,
  // clock the DUT, commit the model, compare.
  task automatic step();
    logic [31:0] n_status, n_cause, n_epc, n_bva, n_count, n_compare;
    logic        n_ti;
    int unsigned n_edges;
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bva = m_bva;
    n_count = m_count; n_compare = m_compare; n_ti = m_ti; n_edges = m_edges;
    if (rst) begin
      n_status = 32'h0040_0000; n_cause = 0; n_epc = 0; n_bva = 0;
      n_count = 0; n_compare = 0; n_ti = 1'b0; n_edges = 0;
    end else begin
      n_edges = m_edges + 1;
      if (m_edges % 2 == 1) n_count = m_count + 1;
      if (m_count == m_compare) n_ti = 1'b1;
      n_cause[15:10] = {hw_int[5] | m_ti, hw_int[4:0]};
      if (exc_valid) begin
        if (!m_status[1]) begin
          n_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
          n_cause[31] = exc_bd;
        end
        n_status[1] = 1'b1;
        n_cause[6:2] = exc_code;
        if (exc_code == 5'h04 || exc_code == 5'h05) n_bva = exc_badvaddr;
      end else if (eret) begin
        n_status[1] = 1'b0;
      end else if (we) begin
        case (waddr)
          5'd9:  n_count = wdata;
          5'd11: begin n_compare = wdata; n_ti = 1'b0; end
          5'd12: n_status = (wdata & 32'h0000_FF03) | 32'h0040_0000;
          5'd13: n_cause[9:8] = wdata[9:8];
          5'd14: n_epc = wdata;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bva = n_bva;
    m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_edges = n_edges;
    check_all();
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badvaddr = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    we = 1; waddr = a; wdata = d;
    step();
    idle();
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic [31:0] bva);
    idle();
    exc_valid = 1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
    step();
    idle();
  endtask

  logic [4:0]  ra_tab [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd5};
  logic [31:0] rv_tab [7] = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 32'h0};
  logic [4:0]  code_tab [7] = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};
  logic [4:0]  addr_tab [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};

  initial begin
    int first_ti;
    idle();
    rst = 1; raddr = 0; hw_int = 0;

    // Reset values, read while reset is held.
    repeat (3) step();
    for (int i = 0; i < 7; i++) begin
      raddr = ra_tab[i];
      #1;
      check($sformatf("reset_rd%0d", ra_tab[i]), rdata, rv_tab[i]);
    end
    check("reset_int", {31'd0, int_pending}, 32'd0);

    // Timer: Compare=10 written on the first edge out of reset.
    rst = 0; raddr = 5'd9;
    mtc0(5'd11, 32'd10);
    first_ti = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (first_ti < 0 && cause_out[30] === 1'b1) first_ti = i;
    end
    check("ti_first_edge", first_ti, 19);
    check("ti_set", {31'd0, cause_out[30]}, 32'd1);
    check("ip7_set", {31'd0, cause_out[15]}, 32'd1);
    mtc0(5'd11, 32'd50);
    check("ti_clear", {31'd0, cause_out[30]}, 32'd0);

    // Exceptions and EXL masking of EPC/BD.
    raddr = 5'd14;
    exc(5'h08, 32'hBFC0_0100, 1'b1, 32'h0);
    check("epc_bd", epc_out, 32'hBFC0_00FC);
    check("cause_bd", {31'd0, cause_out[31]}, 32'd1);
    check("exl_set", {31'd0, status_out[1]}, 32'd1);
    check("exccode", {27'd0, cause_out[6:2]}, 32'h08);
    exc(5'h0c, 32'h0000_0200, 1'b0, 32'h0);
    check("epc_held", epc_out, 32'hBFC0_00FC);
    check("bd_held", {31'd0, cause_out[31]}, 32'd1);

    // BadVAddr capture only for address errors.
    raddr = 5'd8;
    exc(5'h04, 32'h0000_0300, 1'b0, 32'h8000_0003);
    check("bva_adel", rdata, 32'h8000_0003);
    exc(5'h0a, 32'h0000_0304, 1'b0, 32'h1234_5678);
    check("bva_ri", rdata, 32'h8000_0003);

    // Interrupt path and same-cycle exc/eret priority.
    idle(); eret = 1; step(); idle();
    check("eret_exl", {31'd0, status_out[1]}, 32'd0);
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    step();
    check("int_pend", {31'd0, int_pending}, 32'd1);
    idle(); eret = 1; exc_valid = 1; exc_code = 5'h00; exc_pc = 32'h400; step(); idle();
    check("exc_over_eret", {31'd0, status_out[1]}, 32'd1);
    check("int_masked", {31'd0, int_pending}, 32'd0);

    // Write masks.
    mtc0(5'd12, 32'hFFFF_FFFF);
    check("status_mask", status_out, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_sw_ip", {30'd0, cause_out[9:8]}, 32'd3);
    check("cause_ro_bits", cause_out & 32'h3FFF_0083, 32'd0);
    raddr = 5'd8;
    mtc0(5'd8, 32'hDEAD_BEEF);
    check("bva_ro", rdata, 32'h8000_0003);

    // Count wrap: exactly one increment in any two edges.
    raddr = 5'd9;
    mtc0(5'd9, 32'hFFFF_FFFF);
    step(); step();
    check("count_wrap", rdata, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 79) == 0);
      we = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 6) == 0) ? 5'($urandom_range(0, 31))
                                          : addr_tab[$urandom_range(0, 5)];
      wdata = $urandom;
      if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(0, 4);
      if (waddr == 5'd9 && $urandom_range(0, 3) == 0) wdata = 32'hFFFF_FFFC + $urandom_range(0, 3);
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_code = code_tab[$urandom_range(0, 6)];
      exc_pc = $urandom;
      exc_bd = 1'($urandom_range(0, 1));
      exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom_range(0, 63));
      raddr = 5'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 we  in  1  MTC0 write strobe from MEM stage.
REQ-004 waddr  in  5  CP0 register number for write (instr[15:11]).
REQ-005 wdata  in  32  MTC0 write data (GPR[rt]).
REQ-006 raddr  in  5  CP0 register number for MFC0 read.
REQ-007 rdata  out  32  MFC0 read data; combinational from current register contents, no write bypass.
REQ-008 exc_valid  in  1  exception commit strobe (SYSC/BREAK/RI/Ov/AdEL/AdES/Int).
REQ-009 exc_code  in  5  ExcCode of committing exception.
REQ-010 exc_pc  in  32  PC of faulting instruction.
REQ-011 exc_bd  in  1  faulting instruction is in a branch delay slot.
REQ-012 exc_badvaddr  in  32  faulting address (AdEL/AdES only).
REQ-013 eret  in  1  ERET commit strobe.
REQ-014 hw_int  in  6  external hardware interrupt lines, level-sensitive.
REQ-015 epc_out  out  32  current EPC (ERET target).
REQ-016 status_out  out  32  current Status.
REQ-017 cause_out  out  32  current Cause.
REQ-018 int_pending  out  1  unmasked interrupt request to pipeline.

Function
REQ-019 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); rdata for any other raddr = 0.
REQ-020 Status: bit22 BEV read-only 1; bits 15:8 IM, bit1 EXL, bit0 IE writable by MTC0; all other bits read 0.
REQ-021 Cause: bit31 BD, bit30 TI, bits 15:10 IP7..IP2 hardware, bits 9:8 IP1..IP0 MTC0-writable, bits 6:2 ExcCode; others read 0.
REQ-022 Count increments by 1 every second clock (internal toggle tick); wraps 0xFFFFFFFF -> 0; MTC0 to Count loads wdata, tick unaffected.
REQ-023 When Count == Compare (evaluated on registered values, nonzero-cycle compare) Cause.TI sets the following cycle; stays set until MTC0 to Compare, which clears TI the same edge.
REQ-024 Cause.IP[7:2] registered each cycle from {hw_int[5] | TI, hw_int[4:0]}; one-cycle latency from hw_int.
REQ-025 exc_valid with Status.EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; Cause.BD <= exc_bd; EXL <= 1; ExcCode <= exc_code.
REQ-026 exc_valid with Status.EXL=1: ExcCode and EXL updated/held, EPC and BD unchanged.
REQ-027 BadVAddr <= exc_badvaddr only when exc_valid and exc_code is AdEL or AdES.
REQ-028 eret clears Status.EXL next edge; EPC unchanged.
REQ-029 Same-cycle priority: exc_valid > eret > we; lower-priority event discarded entirely.
REQ-030 int_pending = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP); combinational from registers.
REQ-031 MTC0 to Cause writes only IP1..IP0; MTC0 to BadVAddr ignored.

Reset
REQ-032 On rst: Status = 0x0040_0000, Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, tick = 0, int_pending = 0.
REQ-033 rst overrides every same-cycle event (exception, eret, write); reset mid-operation drops pending TI.

Structure
REQ-034 Shared defines header holds CP0 register numbers, ExcCode values (Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0a, Ov 0x0c), Status/Cause bit positions.
REQ-035 One sub-module cp0_timer owns Count, Compare, tick and TI; cp0_regs owns the rest and the read mux.

Verification
REQ-036 Reset, then read all regs -> Status 0x00400000, others 0; raddr 5 -> 0.
REQ-037 MTC0 Compare=10, hold -> TI and Cause bit15 set 1 cycle after Count==10 (~cycle 21); MTC0 Compare=50 -> TI clears same edge.
REQ-038 exc_valid, code 0x08, pc 0xBFC00100, bd=1 -> EPC 0xBFC000FC, BD 1, EXL 1, ExcCode 0x08; second exc_valid pc 0x200 -> EPC unchanged.
REQ-039 exc_valid code 0x04, badvaddr 0x80000003 -> BadVAddr 0x80000003; code 0x0a -> BadVAddr unchanged.
REQ-040 Status=0x0000_0401 via MTC0, hw_int=6'b000001 -> int_pending 1 two cycles later; simultaneous eret+exc_valid -> EXL stays 1.
REQ-041 MTC0 Status=0xFFFFFFFF -> reads 0x0040FF03; MTC0 Cause=0xFFFFFFFF -> only bits 9:8 set.
